design_select_sequencer: RTL and testbench
==========================================

Name: design_select_sequencer

Overview:
- Upstream control stage for the 12-design integration mux.
- Takes design-selection requests from the management interface (logic-analyzer or Wishbone register).
- Drives the mux's design_select and its active-low n_rst, so designs are never switched live.
- Every switch follows the same safe sequence: deselect all designs, then apply the new select with the design held in reset, then release the reset.

Parameters:
NUM_DESIGNS, 12, highest valid design index; valid select values are 0..NUM_DESIGNS, where 0 means no design.
SEL_W, 4, width of the select field.
OFF_CYCLES, 4, cycles spent with all designs deselected during a switch; must be at least 1.
RST_CYCLES, 8, cycles the new design is selected but held in reset; must be at least 1.

Ports:
clk  input  1  system clock; single clock domain.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  a new selection request is present.
req_select  input  SEL_W  requested design index.
req_ready  output  1  sequencer can accept a request.
design_select  output  SEL_W  drives the integration mux's design_select.
design_n_rst  output  1  drives the integration mux's n_rst; active low.
active  output  1  a design is selected and out of reset (state RUN).
err_invalid  output  1  one-cycle pulse when a request is rejected.
cur_select  output  SEL_W  last successfully applied select value.

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state IDLE; design_select=0; design_n_rst=0; req_ready=1; active=0; err_invalid=0; cur_select=0; counter=0.
- Handshake: a request is accepted on the rising edge where req_valid && req_ready. Requests are not queued. Any req_valid while req_ready=0 is ignored; the requester holds it.
- Validity: req_select > NUM_DESIGNS is rejected at acceptance.
  - err_invalid pulses high on the next cycle.
  - State and all other outputs are unchanged.
- States:
  - IDLE: design_select=0, design_n_rst=0, req_ready=1.
  - OFF: design_select=0, design_n_rst=0, req_ready=0, for exactly OFF_CYCLES cycles.
  - APPLY: design_select=pending, design_n_rst=0, req_ready=0, for exactly RST_CYCLES cycles.
  - RUN: design_select=pending, design_n_rst=1, req_ready=1, active=1.
- Transitions:
  - IDLE or RUN, valid request accepted at edge T → OFF from T+1. pending and cur_select latch req_select at T.
  - OFF, counter done → APPLY if pending != 0, otherwise → IDLE.
  - APPLY, counter done → RUN.
- Timing for a nonzero select accepted at edge T:
  - design_select=0 for cycles T+1 .. T+OFF_CYCLES.
  - design_select=new with n_rst low for the next RST_CYCLES cycles.
  - design_n_rst rises and req_ready returns high at T+1+OFF_CYCLES+RST_CYCLES.
- Restart: a request equal to the current select while in RUN is valid. It performs the full OFF/APPLY sequence, acting as a design soft reset.
- Select 0 from RUN: passes through OFF, then IDLE. design_n_rst stays 0 throughout.
- Counter: loaded with OFF_CYCLES-1 on entering OFF and RST_CYCLES-1 on entering APPLY; decrements each cycle; done when it reaches 0. Width is $clog2(max(OFF_CYCLES,RST_CYCLES)).
- rst asserted mid-sequence: immediate return to reset values on the next edge. The pending request is discarded.
- Glitch rules:
  - design_select and design_n_rst are registered outputs; no combinational path from req_* to them.
  - design_select never changes in a cycle where design_n_rst=1.

Decomposition:
- Package design_sel_pkg holds:
  - state enum (IDLE, OFF, APPLY, RUN);
  - NUM_DESIGNS and SEL_W constants, shared with the integration mux.
- Single module; no sub-module is needed (FSM plus one down-counter).

Test Plan:
- Reset, then request select=5 at edge 10 (OFF=4, RST=8) → select=0 for cycles 11–14; select=5 with n_rst=0 for cycles 15–22; n_rst=1, active=1, req_ready=1 at cycle 23; cur_select=5.
- Request select=13 while in IDLE → err_invalid high for exactly one cycle; design_select stays 0; state stays IDLE.
- In RUN with select 5, request select=0 → OFF for 4 cycles, then IDLE; design_n_rst never goes high; active falls the cycle after acceptance.
- In RUN with select 7, request select=7 → n_rst falls one cycle after acceptance; select is 0 for 4 cycles, then 7 in reset for 8 cycles, then RUN.
- Hold req_valid with select=3 during APPLY of a select=9 switch → ignored until RUN; accepted on the first cycle req_ready=1; second sequence completes to select=3.
- Assert rst during APPLY → next cycle design_select=0, design_n_rst=0, req_ready=1, cur_select=0.

Source files
------------

// File: rtl/design_select_sequencer_pkg.sv
// Shared constants and types for the design-select sequencer and the integration mux.
package design_sel_pkg;

  localparam int unsigned NUM_DESIGNS = 12;
  localparam int unsigned SEL_W       = 4;

  typedef enum logic [1:0] {
    IDLE,
    OFF,
    APPLY,
    RUN
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic sel_valid(input logic [SEL_W-1:0] sel);
    return sel <= SEL_W'(NUM_DESIGNS);
  endfunction

endpackage

// File: rtl/design_select_sequencer.sv
// Sequences design switches for the integration mux: deselect all, apply the
// new select with the design held in reset, then release the reset.
module design_select_sequencer
  import design_sel_pkg::*;
#(
  parameter int unsigned OFF_CYCLES = 4,
  parameter int unsigned RST_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [SEL_W-1:0] req_select,
  output logic             req_ready,
  output logic [SEL_W-1:0] design_select,
  output logic             design_n_rst,
  output logic             active,
  output logic             err_invalid,
  output logic [SEL_W-1:0] cur_select
);

  localparam int unsigned CNT_W = max_u(1, $clog2(max_u(OFF_CYCLES, RST_CYCLES)));

  if (OFF_CYCLES < 1) begin : g_bad_off
    $error("OFF_CYCLES must be at least 1");
  end
  if (RST_CYCLES < 1) begin : g_bad_rst
    $error("RST_CYCLES must be at least 1");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] pending_q, pending_d;
  logic [SEL_W-1:0] cur_select_q, cur_select_d;
  logic [SEL_W-1:0] design_select_q, design_select_d;
  logic             design_n_rst_q, design_n_rst_d;
  logic             req_ready_q, req_ready_d;
  logic             active_q, active_d;
  logic             err_invalid_q, err_invalid_d;
  logic             accept;

  // Ready only in IDLE/RUN, so accepting never interrupts a switch in flight.
  assign accept = req_valid && req_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      pending_q       <= '0;
      cur_select_q    <= '0;
      design_select_q <= '0;
      design_n_rst_q  <= 1'b0;
      req_ready_q     <= 1'b1;
      active_q        <= 1'b0;
      err_invalid_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pending_q       <= pending_d;
      cur_select_q    <= cur_select_d;
      design_select_q <= design_select_d;
      design_n_rst_q  <= design_n_rst_d;
      req_ready_q     <= req_ready_d;
      active_q        <= active_d;
      err_invalid_q   <= err_invalid_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    pending_d       = pending_q;
    cur_select_d    = cur_select_q;
    err_invalid_d   = 1'b0;
    design_select_d = '0;
    design_n_rst_d  = 1'b0;
    req_ready_d     = 1'b0;
    active_d        = 1'b0;

    unique case (state_q)
      IDLE, RUN: begin
        if (accept) begin
          if (!sel_valid(req_select)) begin
            err_invalid_d = 1'b1;
          end else begin
            state_d      = OFF;
            cnt_d        = CNT_W'(OFF_CYCLES - 1);
            pending_d    = req_select;
            cur_select_d = req_select;
          end
        end
      end
      OFF: begin
        if (cnt_q == '0) begin
          if (pending_q != '0) begin
            state_d = APPLY;
            cnt_d   = CNT_W'(RST_CYCLES - 1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      APPLY: begin
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs follow the next state so every mux-facing signal is a flop.
    unique case (state_d)
      IDLE: req_ready_d = 1'b1;
      OFF:  ;
      APPLY: design_select_d = pending_d;
      RUN: begin
        design_select_d = pending_d;
        design_n_rst_d  = 1'b1;
        req_ready_d     = 1'b1;
        active_d        = 1'b1;
      end
      default: ;
    endcase
  end

  assign req_ready     = req_ready_q;
  assign design_select = design_select_q;
  assign design_n_rst  = design_n_rst_q;
  assign active        = active_q;
  assign err_invalid   = err_invalid_q;
  assign cur_select    = cur_select_q;

endmodule

// File: tb/tb_design_select_sequencer.sv
// Bench for design_select_sequencer: timeline reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_design_select_sequencer;

  localparam int OFF_C = 4;
  localparam int RST_C = 8;
  localparam int MAXSEL = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [3:0] req_select;
  logic       req_ready;
  logic [3:0] design_select;
  logic       design_n_rst;
  logic       active;
  logic       err_invalid;
  logic [3:0] cur_select;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: elapsed cycles since the last accepted switch define everything.
  int edge_n = 0;
  bit have_seq = 1'b0;
  int seq_edge = 0;
  int seq_sel = 0;
  int m_cur = 0;
  int m_err = 0;
  int m_sel = 0;
  int m_nrst = 0;
  int m_ready = 1;
  int m_active = 0;

  design_select_sequencer #(.OFF_CYCLES(OFF_C), .RST_CYCLES(RST_C)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_select(req_select),
    .req_ready(req_ready), .design_select(design_select), .design_n_rst(design_n_rst),
    .active(active), .err_invalid(err_invalid), .cur_select(cur_select)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    edge_n++;
    if (rst) begin
      have_seq = 1'b0;
      m_cur = 0;
      m_err = 0;
    end else begin
      m_err = 0;
      if (req_valid && m_ready == 1) begin
        if (int'(req_select) > MAXSEL) begin
          m_err = 1;
        end else begin
          have_seq = 1'b1;
          seq_edge = edge_n;
          seq_sel = int'(req_select);
          m_cur = int'(req_select);
        end
      end
    end
    begin
      int e;
      e = edge_n - seq_edge + 1;
      m_sel = 0; m_nrst = 0; m_ready = 1; m_active = 0;
      if (have_seq) begin
        if (e <= OFF_C) begin
          m_ready = 0;
        end else if (seq_sel != 0 && e <= OFF_C + RST_C) begin
          m_sel = seq_sel; m_ready = 0;
        end else if (seq_sel != 0) begin
          m_sel = seq_sel; m_nrst = 1; m_active = 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("m_design_select", int'(design_select), m_sel);
      chk("m_design_n_rst", int'(design_n_rst), m_nrst);
      chk("m_req_ready", int'(req_ready), m_ready);
      chk("m_active", int'(active), m_active);
      chk("m_err_invalid", int'(err_invalid), m_err);
      chk("m_cur_select", int'(cur_select), m_cur);
    end
  end

  task automatic issue(input int sel);
    req_valid = 1'b1;
    req_select = 4'(sel);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic waitn(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_select = '0;
    waitn(2);
    chk_en = 1'b1;
    chk("rst_select", int'(design_select), 0);
    chk("rst_nrst", int'(design_n_rst), 0);
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_cur", int'(cur_select), 0);
    rst = 1'b0;
    waitn(1);

    // Out-of-range request is rejected with a single-cycle pulse.
    issue(13);
    chk("inv_err_pulse", int'(err_invalid), 1);
    chk("inv_sel", int'(design_select), 0);
    waitn(1);
    chk("inv_err_clear", int'(err_invalid), 0);
    chk("inv_ready", int'(req_ready), 1);

    // Switch to 5 from idle.
    issue(5);
    chk("sw5_e1_sel", int'(design_select), 0);
    chk("sw5_e1_ready", int'(req_ready), 0);
    waitn(3);
    chk("sw5_e4_sel", int'(design_select), 0);
    waitn(1);
    chk("sw5_e5_sel", int'(design_select), 5);
    chk("sw5_e5_nrst", int'(design_n_rst), 0);
    waitn(7);
    chk("sw5_e12_nrst", int'(design_n_rst), 0);
    waitn(1);
    chk("sw5_e13_nrst", int'(design_n_rst), 1);
    chk("sw5_e13_active", int'(active), 1);
    chk("sw5_e13_ready", int'(req_ready), 1);
    chk("sw5_cur", int'(cur_select), 5);

    // Deselect from RUN: OFF then IDLE.
    issue(0);
    chk("off_e1_active", int'(active), 0);
    chk("off_e1_nrst", int'(design_n_rst), 0);
    waitn(3);
    chk("off_e4_ready", int'(req_ready), 0);
    waitn(1);
    chk("off_e5_ready", int'(req_ready), 1);
    chk("off_e5_sel", int'(design_select), 0);
    chk("off_e5_nrst", int'(design_n_rst), 0);

    // Restart of the running design.
    issue(7);
    waitn(12);
    chk("r7_run", int'(active), 1);
    issue(7);
    chk("r7_e1_nrst", int'(design_n_rst), 0);
    chk("r7_e1_sel", int'(design_select), 0);
    waitn(4);
    chk("r7_e5_sel", int'(design_select), 7);
    chk("r7_e5_nrst", int'(design_n_rst), 0);
    waitn(8);
    chk("r7_e13_nrst", int'(design_n_rst), 1);

    // Request held during APPLY waits for RUN.
    issue(9);
    waitn(5);
    chk("hold_apply_sel", int'(design_select), 9);
    req_valid = 1'b1;
    req_select = 4'd3;
    begin
      int waited;
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!req_ready && waited < 40);
      chk("hold_wait_cycles", waited, 7);
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("hold_e1_sel", int'(design_select), 0);
    chk("hold_cur", int'(cur_select), 3);
    waitn(12);
    chk("hold_run_sel", int'(design_select), 3);
    chk("hold_run_nrst", int'(design_n_rst), 1);

    // Reset in the middle of APPLY.
    issue(2);
    waitn(6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_sel", int'(design_select), 0);
    chk("mrst_nrst", int'(design_n_rst), 0);
    chk("mrst_ready", int'(req_ready), 1);
    chk("mrst_cur", int'(cur_select), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      if (!req_valid || $urandom_range(0, 3) == 0) begin
        req_valid = ($urandom_range(0, 2) == 0);
        req_select = 4'($urandom_range(0, 15));
      end
    end
    rst = 1'b0;
    req_valid = 1'b0;
    waitn(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
